// File: rtl/isp_uart_rx.sv
// 8N1 UART receiver with 4x oversampling, single-entry output buffer,
// framing-error and overrun pulses.
module isp_uart_rx #(
  parameter int RX_CLK_DIV = 108
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_ferr,
  output logic       rx_overrun
);

  localparam int TW = (RX_CLK_DIV > 1) ? $clog2(RX_CLK_DIV) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  logic          r_sync1;
  logic          r_sync2;
  logic [TW-1:0] r_tickCnt;
  logic          w_tick;
  logic          w_sample;
  state_t        r_state;
  state_t        w_nextState;
  logic [1:0]    r_phase;
  logic [2:0]    r_bitCnt;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_ferr;
  logic          r_overrun;
  logic          w_phaseClr;
  logic          w_phaseInc;
  logic          w_shiftEn;
  logic          w_deliver;
  logic          w_frameErr;

  assign w_sample = r_sync2;
  assign w_tick   = (r_tickCnt == TW'(RX_CLK_DIV - 1));

  // Synchronizer flops idle high so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_tick) r_tickCnt <= '0;
    else               r_tickCnt <= r_tickCnt + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (w_tick) begin
      case (r_state)
        IDLE:      if (!w_sample) w_nextState = START;
        START:     if (r_phase == 2'd1) w_nextState = w_sample ? IDLE : DATA;
        DATA:      if (r_phase == 2'd3 && r_bitCnt == 3'd7) w_nextState = STOP;
        STOP:      if (r_phase == 2'd3) w_nextState = w_sample ? IDLE : WAIT_HIGH;
        WAIT_HIGH: if (w_sample) w_nextState = IDLE;
        default:   w_nextState = IDLE;
      endcase
    end
  end

  // Phase runs 0..3 per bit; START samples at phase 1 to land mid start bit.
  always_comb begin
    w_phaseClr = 1'b0;
    w_phaseInc = 1'b0;
    w_shiftEn  = 1'b0;
    w_deliver  = 1'b0;
    w_frameErr = 1'b0;
    if (w_tick) begin
      case (r_state)
        IDLE: w_phaseClr = 1'b1;
        START: begin
          if (r_phase == 2'd1) w_phaseClr = 1'b1;
          else                 w_phaseInc = 1'b1;
        end
        DATA: begin
          if (r_phase == 2'd3) begin
            w_phaseClr = 1'b1;
            w_shiftEn  = 1'b1;
          end else begin
            w_phaseInc = 1'b1;
          end
        end
        STOP: begin
          if (r_phase == 2'd3) begin
            w_phaseClr = 1'b1;
            w_deliver  = w_sample;
            w_frameErr = !w_sample;
          end else begin
            w_phaseInc = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase  <= 2'd0;
      r_bitCnt <= 3'd0;
      r_shift  <= 8'h00;
    end else begin
      if (w_phaseClr)      r_phase <= 2'd0;
      else if (w_phaseInc) r_phase <= r_phase + 2'd1;
      if (r_state == IDLE) begin
        r_bitCnt <= 3'd0;
      end else if (w_shiftEn) begin
        r_shift  <= {w_sample, r_shift[7:1]};
        r_bitCnt <= r_bitCnt + 3'd1;
      end
    end
  end

  // A full buffer drops the new byte unless it is being consumed this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_ferr    <= w_frameErr;
      r_overrun <= 1'b0;
      if (w_deliver) begin
        if (!r_valid || rx_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data    = r_data;
  assign rx_valid   = r_valid;
  assign rx_ferr    = r_ferr;
  assign rx_overrun = r_overrun;

endmodule

// File: doc/isp_uart_rx.md
ISP_UART_RX -- requirements
Module: isp_uart_rx

Interface
REQ-001 The block SHALL have parameter RX_CLK_DIV, default 108, meaning clock cycles per oversample tick (4 ticks per bit; 50 MHz/4/115200 = 108).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port uart_rx, input, 1 bit: asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 The block SHALL have port rx_data, output, 8 bits: the received byte held in the output buffer.
REQ-006 The block SHALL have port rx_valid, output, 1 bit: high while the output buffer holds an unconsumed byte.
REQ-007 The block SHALL have port rx_ready, input, 1 bit: consumer accepts rx_data in any cycle where rx_valid and rx_ready are both high.
REQ-008 The block SHALL have port rx_ferr, output, 1 bit: one-cycle pulse on a framing error (stop bit sampled low).
REQ-009 The block SHALL have port rx_overrun, output, 1 bit: one-cycle pulse when a completed byte is dropped because the buffer is full.

Function
REQ-010 uart_rx SHALL pass through a 2-flop synchronizer whose flops reset to 1; all sampling SHALL use the synchronizer output.
REQ-011 A tick counter SHALL count 0..RX_CLK_DIV-1, wrap to 0, and assert tick in the cycle it equals RX_CLK_DIV-1; it SHALL run freely from reset.
REQ-012 The FSM SHALL have the states IDLE, START, DATA, STOP and WAIT_HIGH, and SHALL act only on tick cycles.
REQ-013 In IDLE, a tick with a low sample SHALL move the FSM to START with the tick-phase counter cleared.
REQ-014 In START, the line SHALL be resampled 2 ticks after entry (mid start bit). A high sample SHALL be treated as a glitch and return the FSM to IDLE; a low sample SHALL move the FSM to DATA.
REQ-015 In DATA, one bit SHALL be sampled every 4 ticks and shifted in LSB first; after the 8th bit the FSM SHALL move to STOP.
REQ-016 In STOP, the line SHALL be sampled 4 ticks after the last data bit.
REQ-017 If the stop sample is high, the byte SHALL be delivered per REQ-019..021 and the FSM SHALL return to IDLE.
REQ-018 If the stop sample is low, rx_ferr SHALL pulse for exactly one clk cycle, the byte SHALL be discarded, and the FSM SHALL move to WAIT_HIGH.
REQ-019 WAIT_HIGH SHALL return to IDLE on the first tick with a high sample, so a held break produces exactly one rx_ferr.
REQ-020 Delivery: if rx_valid is 0, or rx_valid and rx_ready are both 1 in that cycle, rx_data SHALL load the byte and rx_valid SHALL be 1 in the next cycle (latency: 1 clk after the stop-sample tick).
REQ-021 Delivery with rx_valid=1 and rx_ready=0: the new byte SHALL be dropped, rx_data SHALL be unchanged, and rx_overrun SHALL pulse for one cycle.
REQ-022 Handshake: a cycle with rx_valid=1 and rx_ready=1 and no delivery SHALL clear rx_valid next cycle. rx_data SHALL be stable while rx_valid=1 and rx_ready=0.
REQ-023 rx_ready while rx_valid=0 SHALL have no effect.
REQ-024 The block SHALL sustain back-to-back frames: a start edge immediately after the stop sample tick SHALL be detected.

Reset
REQ-025 On rst=1 at a clk edge, the block SHALL set: FSM=IDLE, tick counter=0, phase counter=0, shift register=0, rx_data=8'h00, rx_valid=0, rx_ferr=0, rx_overrun=0, synchronizer flops=1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no rx_valid, rx_ferr or rx_overrun; after release the block SHALL resynchronize on the next falling edge from idle.

Verification (RX_CLK_DIV=4, so 1 bit = 16 clk)
REQ-027 The bench SHALL cover: frame 0x55 with rx_ready held 1 -> rx_valid pulses 1 cycle with rx_data=8'h55, no rx_ferr, no rx_overrun.
REQ-028 The bench SHALL cover: frames 0xA3 then 0x0F back-to-back with rx_ready=0 -> rx_data=8'hA3 held, rx_valid=1, one rx_overrun pulse at the second stop tick; then rx_ready=1 for 1 cycle -> rx_valid=0.
REQ-029 The bench SHALL cover: frame 0x81 with stop bit low, then line low for 10 bit times -> exactly one rx_ferr pulse, rx_valid stays 0; next valid frame 0x3C received correctly.
REQ-030 The bench SHALL cover: a 1-bit-time-minus-9-clk low glitch (7 clk) on an idle line -> FSM returns to IDLE, no outputs asserted.
REQ-031 The bench SHALL cover: rst asserted during bit 4 of frame 0xFF, released, then frame 0x12 -> only 8'h12 delivered.
REQ-032 The bench SHALL cover: rx_valid=1 and rx_ready=1 in the same cycle as delivery of 0x77 -> rx_data=8'h77, rx_valid stays 1, no rx_overrun.
